// File: rtl/muldiv_sched_if.sv
// muldiv_sched_if: E-stage mult/div request, hazard stall and hilo_reg write bundle.
interface muldiv_sched_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_zero_o;
  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, hilo_we_o, hi_o, lo_o, div_zero_o
  );
  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output stall_o, busy_o, hilo_we_o, hi_o, lo_o, div_zero_o
  );
endinterface

// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle MULT/MULTU/DIV/DIVU scheduler writing hilo_reg.
// Optional MULDIV_EARLY_OUT_EN skips the divide loop when |divisor| > |dividend|.
module muldiv_sched #(
  parameter int MUL_STAGES = 2
) (
  input logic clk,
  input logic rst,
  muldiv_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, nextState;
  logic [4:0]  cnt;
  logic [31:0] aMag, bMag, rem, quot, inAMag, inBMag, remStep, quotStep;
  logic [63:0] prod, prodRes;
  logic [32:0] shifted, diff;
  logic        negQ, negR, accept, isMul, bZero, earlyOut;
  always_comb begin
    accept = bus.start_i & ~bus.flush_i;
    isMul = ~bus.op_i[1];
    inAMag = (~bus.op_i[0] & bus.a_i[31]) ? -bus.a_i : bus.a_i;
    inBMag = (~bus.op_i[0] & bus.b_i[31]) ? -bus.b_i : bus.b_i;
    bZero = bus.b_i == 32'd0;
`ifdef MULDIV_EARLY_OUT_EN
    earlyOut = inBMag > inAMag;
`else
    earlyOut = 1'b0;
`endif
    prod = 64'(aMag) * 64'(bMag);
    prodRes = negQ ? -prod : prod;
    shifted = {rem, quot[31]};
    diff = shifted - {1'b0, bMag};
    remStep = diff[32] ? shifted[31:0] : diff[31:0];
    quotStep = {quot[30:0], ~diff[32]};
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (accept) nextState = isMul ? MUL : (bZero | earlyOut) ? DONE : DIV;
      MUL, DIV: if (cnt == 5'd0) nextState = DONE;
      default:  nextState = IDLE;
    endcase
    if (bus.flush_i) nextState = IDLE;
  end
  assign bus.stall_o = (state == IDLE & accept) | state == MUL | state == DIV;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 5'd0;
      aMag <= 32'd0;
      bMag <= 32'd0;
      rem <= 32'd0;
      quot <= 32'd0;
      negQ <= 1'b0;
      negR <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.hilo_we_o <= 1'b0;
      bus.div_zero_o <= 1'b0;
      bus.hi_o <= 32'd0;
      bus.lo_o <= 32'd0;
    end else begin
      bus.busy_o <= nextState != IDLE;
      bus.hilo_we_o <= nextState == DONE;
      bus.div_zero_o <= state == IDLE & accept & ~isMul & bZero;
      case (state)
        IDLE: if (accept) begin
          aMag <= inAMag;
          bMag <= inBMag;
          rem <= 32'd0;
          quot <= inAMag;
          negQ <= ~bus.op_i[0] & (bus.a_i[31] ^ bus.b_i[31]);
          negR <= ~bus.op_i[0] & bus.a_i[31];
          cnt <= isMul ? 5'(MUL_STAGES - 1) : 5'd31;
          if (~isMul & (bZero | earlyOut)) begin
            bus.hi_o <= bus.a_i;
            bus.lo_o <= bZero ? 32'hFFFF_FFFF : 32'd0;
          end
        end
        MUL: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            bus.hi_o <= prodRes[63:32];
            bus.lo_o <= prodRes[31:0];
          end
        end
        DIV: begin
          cnt <= cnt - 5'd1;
          rem <= remStep;
          quot <= quotStep;
          if (cnt == 5'd0) begin
            bus.hi_o <= negR ? -remStep : remStep;
            bus.lo_o <= negQ ? -quotStep : quotStep;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed vectors with a scoreboard checking every hilo write.
module tb_muldiv_sched;
  localparam int MS = 2;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EOLAT = 1;
`else
  localparam int EOLAT = 33;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  muldiv_sched_if bus();
  muldiv_sched #(.MUL_STAGES(MS)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          at;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int pass = 0;
  int total = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk)
    if (rst && bus.hilo_we_o) begin
      if (q.size() == 0) chk("spurious_we", 64'(bus.hilo_we_o), 64'd0);
      else begin
        e = q.pop_front();
        chk("hi", bus.hi_o, e.hi);
        chk("lo", bus.lo_o, e.lo);
        chk("div_zero", bus.div_zero_o, e.dz);
        chk("we_cycle", cyc, e.at);
      end
    end
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                       input int lat, input string name);
    int st = 0;
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.a_i = a;
    bus.b_i = b;
    q.push_back('{hi, lo, dz, cyc + lat});
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      st += int'(bus.stall_o);
      if (i == 0) chk({name, "_busy0"}, bus.busy_o, 0);
      if (i == 1) chk({name, "_busy1"}, bus.busy_o, 1);
    end
    chk({name, "_stall"}, st, lat);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask
  task automatic chkIdle(input string name);
    chk({name, "_we"}, bus.hilo_we_o, 0);
    chk({name, "_hi"}, bus.hi_o, 0);
    chk({name, "_lo"}, bus.lo_o, 0);
    chk({name, "_dz"}, bus.div_zero_o, 0);
    chk({name, "_busy"}, bus.busy_o, 0);
    chk({name, "_stall"}, bus.stall_o, 0);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i = 2'd0;
    bus.a_i = 32'd0;
    bus.b_i = 32'd0;
    repeat (2) @(negedge clk);
    chkIdle("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    runOp(2'd1, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, MS + 1, "multu");
    runOp(2'd0, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MS + 1, "mult");
    runOp(2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, "div");
    runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, "div_ovf");
    runOp(2'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1, "divu_zero");
    runOp(2'd3, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, EOLAT, "divu_early");
    runOp(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, "divu");
    runOp(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 1'b0, MS + 1, "mult_max");
    runOp(2'd2, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, "div_negb");
    runOp(2'd2, -32'sd8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 1, "div_zero");
    runOp(2'd2, -32'sd3, 32'd10, 32'hFFFF_FFFD, 32'd0, 1'b0, EOLAT, "div_early");
    runOp(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, MS + 1, "mult_min");
    bus.start_i = 1'b1;
    bus.op_i = 2'd3;
    bus.a_i = 32'd100;
    bus.b_i = 32'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    chk("flush_busy", bus.busy_o, 0);
    runOp(2'd1, 32'h1_0000, 32'h1_0000, 32'h1, 32'h0, 1'b0, MS + 1, "multu_after_flush");
    bus.start_i = 1'b1;
    bus.op_i = 2'd3;
    bus.a_i = 32'd100;
    bus.b_i = 32'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.start_i = 1'b0;
    #1 chkIdle("midop_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    runOp(2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, MS + 1, "multu_after_rst");
    repeat (40) @(posedge clk);
    chk("pending", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
